// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and defaults for the instruction fetch queue.
//   - fetch_state_e : fetch FSM states (BOOT / FETCH / HALT)
//   - DEF_DEPTH     : default queue depth and outstanding-request limit
//   - DEF_RESET_PC  : default first fetch address after reset
//   - fq_entry_t    : one queue entry {pc, instr}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          DEF_DEPTH    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Instruction queue storage: synchronous write, first-word-fall-through read.
//   Ports:
//     clk, rst      : clock / async active-high reset
//     flush         : drop every entry (wins over push and pop)
//     push, wdata   : write one entry
//     pop           : consume the head entry
//     rdata         : head entry, reads 0 while empty
//     empty, count  : occupancy status
//   Push and pop in the same cycle both complete, also when full.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fq_entry_t     wdata,
    input  logic          pop,
    output fq_entry_t     rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    fq_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A full queue still accepts a write when the head leaves this cycle.
    assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: rdata is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Issues sequential word fetches to instruction memory, queues the returned
//   words with their PCs and hands them to the core (FWFT). A redirect flushes
//   the queue and discards responses to requests already in flight.
//   Parameters: DEPTH (queue entries = max outstanding), RESET_PC.
//   Ports:
//     clk, rst                           : clock / async active-high reset
//     imem_req_valid/ready/addr          : fetch request channel
//     imem_rsp_valid/data                : in-order response channel
//     redirect_valid/pc                  : taken branch from the core
//     instr_valid/ready/data/pc          : instruction output to the core
//     misalign_err                       : sticky misaligned-redirect flag
//   Build option: FETCH_MISALIGN_CHK_EN -- a redirect to a non-word-aligned
//   target sets misalign_err and halts fetch; otherwise the low two target
//   bits are cleared and misalign_err is constant 0.
// -----------------------------------------------------------------------------
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEF_DEPTH,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state, state_nxt;
    logic [31:0]   fetch_pc;      // next address to request
    logic [31:0]   rsp_pc;        // PC of the next response that will be kept
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    logic          fifo_empty;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          misalign;
    logic [31:0]   redir_pc;
    fq_entry_t     wentry;
    fq_entry_t     head;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redir_pc = redirect_pc;
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_pc = redirect_pc & ~32'h3;
    assign misalign = 1'b0;
`endif

    assign req_fire = imem_req_valid && imem_req_ready;
    // Redirect wins over a simultaneous dequeue and drops that cycle's response.
    assign pop      = instr_valid && instr_ready && !redirect_valid;
    assign push     = imem_rsp_valid && (discard_cnt == '0) && !redirect_valid;
    // Every response retires one outstanding request, kept or discarded.
    assign out_nxt  = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    // Counting the entry leaving this cycle lets a full queue restart fetch
    // in the same cycle the core drains it; the slot is free by the time any
    // response to the new request can arrive.
    assign inflight = (CW+1)'(fifo_count) + (CW+1)'(outstanding) - (CW+1)'(pop);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   state_nxt = FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
        if (misalign) state_nxt = HALT;
    end

    always_comb begin
        imem_req_valid = (state == FETCH) && (inflight < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc;
    end

    // ---------------- PC / request tracking ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= out_nxt;
            if (redirect_valid) begin
                fetch_pc    <= redir_pc;
                rsp_pc      <= redir_pc;
                // Everything still in flight after this cycle is stale.
                discard_cnt <= out_nxt;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (push)     rsp_pc   <= rsp_pc + 32'd4;
                if (imem_rsp_valid && (discard_cnt != '0))
                    discard_cnt <= discard_cnt - CW'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           misalign_err <= 1'b0;
        else if (misalign) misalign_err <= 1'b1;
    end
`else
    assign misalign_err = 1'b0;
`endif

    // ---------------- queue ----------------
    always_comb begin
        wentry       = '0;
        wentry.pc    = rsp_pc;
        wentry.instr = imem_rsp_data;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Directed scenarios followed by a randomized run. A behavioural memory
//   (queue of accepted addresses with due cycles) answers requests in order;
//   the expected instruction stream is simply "target, target+4, ..." after
//   each redirect (or reset), with data = memfn(pc).
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        misalign_err;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] post_pcs[$];   // PCs delivered since the last redirect/reset
    logic [31:0] exp_pc, exp_req;
    int          tests = 0, fails = 0;
    int          cyc = 0, nreq = 0, ndeliv = 0;
    int          p_ready = 100, p_rsp = 100, p_iready = 100;
    int          lat_lo = 1, lat_hi = 1;
    bit          expect_gap = 0;
    bit          last_ivld, last_rqv, last_rspv;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] pget(input int i);
        if (i < post_pcs.size()) return post_pcs[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Entered with clk low; leaves at a negedge with rst released.
    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        chk("rst instr_valid",    32'(instr_valid), 0);
        chk("rst imem_req_valid", 32'(imem_req_valid), 0);
        chk("rst misalign_err",   32'(misalign_err), 0);
        chk("rst instr_pc",       instr_pc, 0);
        chk("rst instr_data",     instr_data, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        memq.delete();
        post_pcs.delete();
        exp_pc     = RESET_PC;
        exp_req    = RESET_PC;
        expect_gap = 0;
        cyc        = 0;
    endtask

    // One clock cycle: drive at negedge, sample, let the edge happen, update model.
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit          rf;
        logic [31:0] raddr;
        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(0, 99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        instr_ready    = ($urandom_range(0, 99) < p_iready);
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        last_ivld = instr_valid;
        last_rqv  = imem_req_valid;
        last_rspv = imem_rsp_valid;
        if (expect_gap) chk("valid after redirect", 32'(instr_valid), 0);
        chk("outstanding bound", 32'(memq.size() <= DEPTH), 1);
        rf    = imem_req_valid && imem_req_ready;
        raddr = imem_req_addr;
        if (rf) begin
            chk("req addr", raddr, exp_req);
            nreq++;
        end
        if (instr_valid && instr_ready && !redir) begin
            chk("instr pc", instr_pc, exp_pc);
            chk("instr data", instr_data, memfn(exp_pc));
            post_pcs.push_back(instr_pc);
            exp_pc = exp_pc + 32'd4;
            ndeliv++;
        end
        @(posedge clk);
        if (imem_rsp_valid) void'(memq.pop_front());
        if (rf) memq.push_back('{raddr, cyc + $urandom_range(lat_lo, lat_hi)});
        if (redir) begin
            exp_pc  = tgt & ~32'h3;
            exp_req = tgt & ~32'h3;
            post_pcs.delete();
        end else if (rf) begin
            exp_req = exp_req + 32'd4;
        end
        expect_gap = redir;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    initial begin
        int first, d0, n0;
        logic [31:0] tgt;
        #2;
        do_reset();

        // Streaming: always ready, latency 1.
        first = 0;
        for (int s = 1; s <= 14; s++) begin
            step(1'b0, 32'h0);
            if (last_ivld && first == 0) first = s;
        end
        chk("first valid within 3 edges", 32'(first != 0 && first - 1 <= 3), 1);
        chk("first pc", pget(0), 32'h0);
        d0 = ndeliv;
        run(10);
        chk("one instr per cycle", 32'(ndeliv - d0), 10);

        // Core stalls: exactly DEPTH requests, then full.
        do_reset();
        p_iready = 0;
        n0 = nreq;
        run(20);
        chk("requests while stalled", 32'(nreq - n0), DEPTH);
        chk("req_valid when full", 32'(last_rqv), 0);
        chk("valid when full", 32'(last_ivld), 1);
        p_iready = 100;
        d0 = ndeliv;
        step(1'b0, 32'h0);
        chk("fetch resumes same cycle", 32'(last_rqv), 1);
        run(3);
        chk("drained count", 32'(ndeliv - d0), 4);
        chk("fourth pc", pget(3), 32'hC);

        // Latency 3, redirect with two requests in flight.
        do_reset();
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 20 && memq.size() != 2; i++) step(1'b0, 32'h0);
        chk("two outstanding", 32'(memq.size()), 2);
        step(1'b1, 32'h100);
        run(15);
        chk("pc after stale discard", pget(0), 32'h100);
        chk("second pc after redirect", pget(1), 32'h104);

        // Redirect together with a handshake and a response.
        do_reset();
        lat_lo = 1; lat_hi = 1;
        run(8);
        step(1'b1, 32'h240);
        chk("handshake and rsp at redirect", 32'(last_ivld && last_rspv && instr_ready), 1);
        run(8);
        chk("restart at target", pget(0), 32'h240);

        // Address wrap.
        step(1'b1, 32'hFFFF_FFF8);
        run(10);
        chk("wrap pc0", pget(0), 32'hFFFF_FFF8);
        chk("wrap pc1", pget(1), 32'hFFFF_FFFC);
        chk("wrap pc2", pget(2), 32'h0000_0000);

        // Randomized traffic with redirects and a mid-run reset.
        p_ready = 70; p_rsp = 75; p_iready = 60;
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h3);
            step($urandom_range(0, 99) < 3, tgt);
        end

        // Misaligned redirect.
        p_ready = 100; p_rsp = 100; p_iready = 100;
        lat_lo = 1; lat_hi = 1;
        run(10);
        step(1'b1, 32'h102);
        n0 = nreq;
        run(10);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("no requests after misalign", 32'(nreq - n0), 0);
        chk("misalign_err set", 32'(misalign_err), 1);
`else
        chk("misaligned target masked", pget(0), 32'h100);
        chk("misalign_err clear", 32'(misalign_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
